// File: rtl/agc_bank_regs.sv
// Bank-select register block: owns EB, FB and the superbank bit (channel 7)
// that the address translator reads, plus a one-entry interrupt shadow.
module agc_bank_regs #(
  parameter logic [11:0] EB_ADDR     = 12'o0003,
  parameter logic [11:0] FB_ADDR     = 12'o0004,
  parameter logic [11:0] BB_ADDR     = 12'o0006,
  parameter logic [8:0]  FEB_CHAN    = 9'o007,
  parameter int unsigned FEB_BIT     = 6,
  parameter logic [4:0]  RESET_FBANK = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [11:0] mem_addr,
  input  logic [14:0] mem_wdata,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [8:0]  io_addr,
  input  logic [14:0] io_wdata,
  input  logic        save,
  input  logic        restore,
  output logic [14:0] rdata,
  output logic        rvalid,
  output logic        hit,
  output logic [2:0]  eBank,
  output logic [4:0]  fBank,
  output logic        superBank
);

  // Address decode, shared by reads and writes.
  logic isEb, isFb, isBb, isChan;
  assign isEb   = (mem_addr == EB_ADDR);
  assign isFb   = (mem_addr == FB_ADDR);
  assign isBb   = (mem_addr == BB_ADDR);
  assign isChan = (io_addr == FEB_CHAN);

  logic memHit, ioHit;
  assign memHit = (mem_wr | mem_rd) & (isEb | isFb | isBb);
  assign ioHit  = (io_wr | io_rd) & isChan;
  assign hit    = memHit | ioHit;

  logic ebWr, fbWr, bbWr, chanWr;
  assign ebWr   = mem_wr & isEb;
  assign fbWr   = mem_wr & isFb;
  assign bbWr   = mem_wr & isBb;
  assign chanWr = io_wr & isChan;

  logic memRdHit, ioRdHit;
  assign memRdHit = mem_rd & (isEb | isFb | isBb);
  assign ioRdHit  = io_rd & isChan;

  // Shadow copy for interrupt save/restore.
  logic [2:0] shadowEb;
  logic [4:0] shadowFb;
  logic       shadowSb;

  // Next bank values: restore beats BB, BB beats the single-field writes.
  logic [2:0] eBankNext;
  logic [4:0] fBankNext;
  logic       superBankNext;

  always_comb begin
    eBankNext     = eBank;
    fBankNext     = fBank;
    superBankNext = superBank;
    if (restore) begin
      eBankNext     = shadowEb;
      fBankNext     = shadowFb;
      superBankNext = shadowSb;
    end else begin
      if (bbWr) begin
        eBankNext = mem_wdata[2:0];
        fBankNext = mem_wdata[14:10];
      end else if (ebWr) begin
        eBankNext = mem_wdata[10:8];
      end else if (fbWr) begin
        fBankNext = mem_wdata[14:10];
      end
      if (chanWr) begin
        superBankNext = io_wdata[FEB_BIT];
      end
    end
  end

  // Read formatting uses the pre-write register values, so a read and
  // write to the same register in one cycle returns the old contents.
  logic [14:0] chanWord;
  always_comb begin
    chanWord          = '0;
    chanWord[FEB_BIT] = superBank;
  end

  logic [14:0] memWord;
  always_comb begin
    memWord = '0;
    if (isEb) begin
      memWord = {4'b0, eBank, 8'b0};
    end else if (isFb) begin
      memWord = {fBank, 10'b0};
    end else if (isBb) begin
      memWord = {fBank, 7'b0, eBank};
    end
  end

  // Read handshake: rvalid is a single-cycle pulse with no back-pressure;
  // rdata is meaningful only while rvalid is high and otherwise holds.
  // A mem read takes precedence over a concurrent channel read.
  logic        rdFire;
  logic [14:0] rdataNext;
  always_comb begin
    rdFire    = memRdHit | ioRdHit;
    rdataNext = rdata;
    if (memRdHit) begin
      rdataNext = memWord;
    end else if (ioRdHit) begin
      rdataNext = chanWord;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eBank     <= 3'd0;
      fBank     <= RESET_FBANK;
      superBank <= 1'b0;
      shadowEb  <= 3'd0;
      shadowFb  <= RESET_FBANK;
      shadowSb  <= 1'b0;
      rdata     <= 15'd0;
      rvalid    <= 1'b0;
    end else begin
      eBank     <= eBankNext;
      fBank     <= fBankNext;
      superBank <= superBankNext;
      // Shadow captures the values held before this edge; with a concurrent
      // restore this produces a swap.
      if (save) begin
        shadowEb <= eBank;
        shadowFb <= fBank;
        shadowSb <= superBank;
      end
      rdata  <= rdataNext;
      rvalid <= rdFire;
    end
  end

endmodule
